fp_addsub_unit: RTL

IEEE-754 single-precision add/subtract execution unit. It sits directly downstream of the FPU controller: it consumes the controller's start_alu pulse and 2-bit ALU control code, and returns the alu_done pulse that moves the controller out of CALC. The unit is a fixed-latency multi-cycle FSM with align, add, normalize and round stages. Multiply and divide codes are handled by a sibling unit, not this one.

---
 rtl/fp_addsub_unit.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_unit.sv
// rtl/fp_addsub_unit.sv - IEEE-754 binary32 add/subtract unit, fixed 5-edge latency
//
// Purpose: services add (alu_control=00) and sub (01) requests from the FPU
// controller. Operands are latched on an accepted start and processed through
// ALIGN -> ADD -> NORM -> ROUND -> DONE. Rounding is round-to-nearest-even;
// denormal inputs are flushed to zero.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             start pulse (start_alu)
//   alu_control[1:0]  00 add, 01 sub, 1x ignored
//   a, b [31:0]       binary32 operands
//   result [31:0]     binary32 result, held until the next accepted start
//   done              one-cycle completion pulse, 5 edges after the start edge
//   busy              high from accept through the done cycle
//   flag_*            overflow / underflow / invalid / inexact, held with result
module fp_addsub_unit #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  alu_control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        flag_overflow,
  output logic        flag_underflow,
  output logic        flag_invalid,
  output logic        flag_inexact
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t state_q, state_d;
  logic        done_q;
  logic [31:0] result_q;
  logic [3:0]  flags_q;   // {overflow, underflow, invalid, inexact}
  logic        accept;

  // Pipeline-stage registers (no reset needed: only consumed after an accept)
  logic [31:0]       op_a_q, op_b_q;        // op_b_q already sign-flipped for sub
  logic [26:0]       xs_q, ys_q;            // {sig, G, R, S}
  logic              sign_q, eff_sub_q;
  logic signed [9:0] exp_q;
  logic              spec_q, spec_inv_q;
  logic [31:0]       spec_res_q;
  logic [27:0]       sum_q;
  logic [26:0]       norm_m_q;
  logic signed [9:0] norm_e_q;
  logic              zero_q;

  // done is registered off the DONE state so the pulse lands one edge later,
  // giving the fixed 5-edge start-to-done latency; start is still refused then.
  assign accept = (state_q == S_IDLE) && !done_q && start && !alu_control[1];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_DONE);
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q != S_IDLE) || done_q;
    done = done_q;
  end

  // ---------------- ALIGN: unpack, swap, shift, specials ----------------
  logic [7:0]  a_exp, b_exp, x_exp, y_exp, diff;
  logic [23:0] a_sig, b_sig, x_sig, y_sig;
  logic        a_nan, b_nan, a_inf, b_inf, swap, x_sign, y_sign;
  logic [26:0] y_ext, y_al;
  logic        spec_d, spec_inv_d;
  logic [31:0] spec_res_d;

  always_comb begin
    a_exp = op_a_q[30:23];
    b_exp = op_b_q[30:23];
    a_sig = (a_exp != 8'd0) ? {1'b1, op_a_q[22:0]} : 24'd0;
    b_sig = (b_exp != 8'd0) ? {1'b1, op_b_q[22:0]} : 24'd0;
    a_nan = (a_exp == 8'hFF) && (op_a_q[22:0] != 23'd0);
    b_nan = (b_exp == 8'hFF) && (op_b_q[22:0] != 23'd0);
    a_inf = (a_exp == 8'hFF) && (op_a_q[22:0] == 23'd0);
    b_inf = (b_exp == 8'hFF) && (op_b_q[22:0] == 23'd0);
    // Magnitude compare on the flushed operands
    swap   = {b_exp, b_sig[22:0]} > {a_exp, a_sig[22:0]};
    x_exp  = swap ? b_exp : a_exp;
    y_exp  = swap ? a_exp : b_exp;
    x_sig  = swap ? b_sig : a_sig;
    y_sig  = swap ? a_sig : b_sig;
    x_sign = swap ? op_b_q[31] : op_a_q[31];
    y_sign = swap ? op_a_q[31] : op_b_q[31];
    diff   = x_exp - y_exp;
    y_ext  = {y_sig, 3'b000};
    if (diff > 8'd26) begin
      y_al = {26'd0, |y_sig};
    end else begin
      y_al    = y_ext >> diff[4:0];
      y_al[0] = y_al[0] | (|(y_ext & ((27'd1 << diff[4:0]) - 27'd1)));
    end
    spec_d     = 1'b1;
    spec_inv_d = 1'b0;
    spec_res_d = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (op_a_q[31] != op_b_q[31])))
      spec_inv_d = 1'b1;
    else if (a_inf)
      spec_res_d = op_a_q;
    else if (b_inf)
      spec_res_d = op_b_q;
    else
      spec_d = 1'b0;
  end

  // ---------------- NORM: leading-zero count ----------------
  logic [4:0] lz;
  logic       lz_found;
  always_comb begin
    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found) begin
        if (sum_q[i]) lz_found = 1'b1;
        else          lz = lz + 5'd1;
      end
    end
  end

  // ---------------- ROUND: RNE and range check ----------------
  logic              rnd_inc, rnd_inx;
  logic [24:0]       rnd_m;
  logic signed [9:0] rnd_e;
  logic [31:0]       res_d;
  logic [3:0]        flags_d;

  always_comb begin
    rnd_inc = norm_m_q[2] & (norm_m_q[1] | norm_m_q[0] | norm_m_q[3]);
    rnd_inx = |norm_m_q[2:0];
    rnd_m   = {1'b0, norm_m_q[26:3]} + {24'd0, rnd_inc};
    rnd_e   = norm_e_q + {9'd0, rnd_m[24]};
    res_d   = {sign_q, rnd_e[7:0], rnd_m[24] ? 23'd0 : rnd_m[22:0]};
    flags_d = {3'b000, rnd_inx};
    if (spec_q) begin
      res_d   = spec_res_q;
      flags_d = {2'b00, spec_inv_q, 1'b0};
    end else if (zero_q) begin
      // Exact zero: negative only when both addends were negative zeros
      res_d   = {sign_q & ~eff_sub_q, 31'd0};
      flags_d = 4'b0000;
    end else if (rnd_e >= 10'sd255) begin
      res_d   = {sign_q, 8'hFF, 23'd0};
      flags_d = 4'b1001;
    end else if (rnd_e <= 10'sd0) begin
      res_d   = {sign_q, 31'd0};
      flags_d = 4'b0101;
    end
  end

  // ---------------- Datapath stage registers ----------------
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_q <= a;
      op_b_q <= {b[31] ^ alu_control[0], b[30:0]};
    end
    if (state_q == S_ALIGN) begin
      xs_q       <= {x_sig, 3'b000};
      ys_q       <= y_al;
      sign_q     <= x_sign;
      eff_sub_q  <= x_sign ^ y_sign;
      exp_q      <= {2'b00, x_exp};
      spec_q     <= spec_d;
      spec_inv_q <= spec_inv_d;
      spec_res_q <= spec_res_d;
    end
    if (state_q == S_ADD)
      sum_q <= eff_sub_q ? ({1'b0, xs_q} - {1'b0, ys_q}) : ({1'b0, xs_q} + {1'b0, ys_q});
    if (state_q == S_NORM) begin
      zero_q <= (sum_q == 28'd0);
      if (sum_q[27]) begin
        norm_m_q <= {sum_q[27:2], sum_q[1] | sum_q[0]};
        norm_e_q <= exp_q + 10'sd1;
      end else begin
        norm_m_q <= sum_q[26:0] << lz;
        norm_e_q <= exp_q - $signed({5'd0, lz});
      end
    end
  end

  // ---------------- Result / flags ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 32'd0;
      flags_q  <= 4'd0;
    end else if (state_q == S_ROUND) begin
      result_q <= res_d;
      flags_q  <= flags_d;
    end
  end

  assign result         = result_q;
  assign flag_overflow  = flags_q[3];
  assign flag_underflow = flags_q[2];
  assign flag_invalid   = flags_q[1];
  assign flag_inexact   = flags_q[0];

endmodule
